wave_unit_sequencer: RTL
========================

// Module: wave_unit_sequencer
// PURPOSE
//  Sequences the unit-based sample FIFO between the ADC front end and the packet sender.
//  - Write side: on each trigger, waits a programmable delay, then writes exactly one unit of ADC samples.
//  - Read side: drains whole units to the sender as framed packets (SOP/EOP).
//  - Sole driver of the FIFO wr/rd strobes; FIFO full/empty flags change only on unit boundaries.
// PARAMETERS
//  DATA_WIDTH       8   sample width
//  UNIT_SIZE_WIDTH  13  width of unit-size and sample counters
//  DELAY_WIDTH      16  width of trigger-to-capture delay counter
//  DROP_WIDTH       8   width of saturating dropped-trigger counter
// PORTS
//  i_clk            in   1    clock
//  i_rst_n          in   1    reset, asynchronous, active-low
//  i_trig           in   1    acquisition trigger, single-cycle pulse
//  i_delay          in   DELAY_WIDTH      trigger-to-first-sample delay, in clocks
//  i_unit_size_dec  in   UNIT_SIZE_WIDTH  unit size - 1; same value as the FIFO's
//  i_adc_data       in   DATA_WIDTH       ADC sample
//  i_fifo_full      in   1    FIFO full flag
//  i_fifo_empty     in   1    FIFO empty flag
//  i_fifo_rdata     in   DATA_WIDTH       FIFO read data
//  i_fifo_rd_effect in   1    FIFO read-data valid, 1 clk after rd
//  i_tx_ready       in   1    sender can accept data
//  o_fifo_wr        out  1    FIFO write strobe
//  o_fifo_wdata     out  DATA_WIDTH       FIFO write data
//  o_fifo_rd        out  1    FIFO read strobe
//  o_tx_data        out  DATA_WIDTH       packet data
//  o_tx_valid       out  1    packet data valid
//  o_tx_sop         out  1    first beat of a unit
//  o_tx_eop         out  1    last beat of a unit
//  o_drop_cnt       out  DROP_WIDTH       triggers dropped because the FIFO was full; saturates
//  o_busy           out  1    either FSM not idle
// BEHAVIOUR
//  Reset: all outputs 0; both FSMs IDLE; internal counters 0.
//   Reset mid-burst abandons the unit; the FIFO shares the reset.
//  Write FSM: W_IDLE -> W_DELAY -> W_CAPTURE.
//   - W_IDLE + i_trig:
//     - i_fifo_full=1: o_drop_cnt += 1 (saturating); stay in W_IDLE.
//     - i_delay=0: go to W_CAPTURE.
//     - otherwise: load i_delay into the delay counter; go to W_DELAY.
//   - i_trig outside W_IDLE is ignored and not counted.
//   - W_DELAY: decrement the delay counter; at 1, go to W_CAPTURE.
//     Result: first write occurs i_delay+1 clocks after the trigger.
//   - W_CAPTURE: o_fifo_wr=1 every clock.
//     - o_fifo_wdata = i_adc_data registered (1-clk pipe).
//     - Sample counter runs 0..unit_size_dec; the write at unit_size_dec is the last; then W_IDLE.
//   - i_unit_size_dec is latched on entry to W_DELAY or W_CAPTURE. The capture never stalls:
//     the full flag cannot rise mid-unit and space was checked at the trigger.
//  Read FSM: R_IDLE -> R_BURST -> R_FLUSH.
//   - R_IDLE: when i_fifo_empty=0 and i_tx_ready=1, go to R_BURST; i_unit_size_dec is latched.
//   - R_BURST: o_fifo_rd = i_tx_ready.
//     - The read counter advances on each rd; after the rd at count unit_size_dec, go to R_FLUSH.
//     - The sink must accept one beat after deasserting i_tx_ready, because of the 1-clk read latency.
//   - R_FLUSH: wait for the last i_fifo_rd_effect, then go to R_IDLE (1 clk).
//   - Back-to-back units: re-entry from R_IDLE happens no earlier than the clock after R_FLUSH.
//  TX outputs (combinational from FIFO outputs and beat counter):
//   - o_tx_valid = i_fifo_rd_effect; o_tx_data = i_fifo_rdata.
//   - o_tx_sop on the first valid beat of a burst; o_tx_eop on beat unit_size_dec.
//   - A unit size of 1 (dec=0) gives SOP and EOP on the same beat.
//  Simultaneous capture and burst are legal.
//   - o_fifo_wr and o_fifo_rd may be high in the same clk.
//  o_busy = (write FSM != W_IDLE) | (read FSM != R_IDLE).
// TESTING
//  1. dec=3, delay=0, tx_ready=1, trig @t0 -> wr high t1..t4 with ADC t0..t3;
//     tx emits 4 beats, SOP on beat 0, EOP on beat 3, drop_cnt=0.
//  2. delay=5, trig -> first o_fifo_wr 6 clks after the trigger;
//     a 2nd trig during W_DELAY is ignored (exactly 1 unit written).
//  3. Fill the FIFO (8 units, tx_ready=0), trig x3 -> no writes, drop_cnt=3;
//     force 255 drops -> drop_cnt holds at 255.
//  4. dec=7 burst, toggle tx_ready 0/1 every 2 clks -> exactly 8 valid beats,
//     correct data order, single SOP/EOP.
//  5. Capture and readout of different units overlapped
//     -> data intact; wr and rd strobes coincide at least once.
//  6. i_rst_n low mid-burst (beat 3 of 8) -> all outputs 0 asynchronously;
//     after release both FSMs idle, no spurious valid.

Source files
------------

// File: rtl/wave_unit_sequencer.sv
// wave_unit_sequencer: drives the wr/rd strobes of a unit-based sample FIFO,
// capturing one ADC unit per trigger and draining whole units as SOP/EOP packets.
//
// Ports:
//   i_clk, i_rst_n     clock, asynchronous active-low reset
//   i_trig             acquisition trigger (single-cycle pulse)
//   i_delay            clocks from trigger to capture start (first write at delay+1)
//   i_unit_size_dec    unit size minus one, shared with the FIFO
//   i_adc_data         ADC sample stream, registered once before the FIFO
//   i_fifo_full/empty  unit-granular FIFO flags
//   i_fifo_rdata       FIFO read data, valid with i_fifo_rd_effect
//   i_fifo_rd_effect   read-data valid, one clock after o_fifo_rd
//   i_tx_ready         sender back-pressure
//   o_fifo_wr/wdata    FIFO write strobe and data
//   o_fifo_rd          FIFO read strobe
//   o_tx_*             packet beat data/valid/SOP/EOP
//   o_drop_cnt         saturating count of triggers refused for lack of space
//   o_busy             either sequencer active
module wave_unit_sequencer #(
    parameter int DATA_WIDTH      = 8,
    parameter int UNIT_SIZE_WIDTH = 13,
    parameter int DELAY_WIDTH     = 16,
    parameter int DROP_WIDTH      = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_trig,
    input  logic [DELAY_WIDTH-1:0]     i_delay,
    input  logic [UNIT_SIZE_WIDTH-1:0] i_unit_size_dec,
    input  logic [DATA_WIDTH-1:0]      i_adc_data,
    input  logic                       i_fifo_full,
    input  logic                       i_fifo_empty,
    input  logic [DATA_WIDTH-1:0]      i_fifo_rdata,
    input  logic                       i_fifo_rd_effect,
    input  logic                       i_tx_ready,
    output logic                       o_fifo_wr,
    output logic [DATA_WIDTH-1:0]      o_fifo_wdata,
    output logic                       o_fifo_rd,
    output logic [DATA_WIDTH-1:0]      o_tx_data,
    output logic                       o_tx_valid,
    output logic                       o_tx_sop,
    output logic                       o_tx_eop,
    output logic [DROP_WIDTH-1:0]      o_drop_cnt,
    output logic                       o_busy
);

    typedef enum logic [1:0] {
        W_IDLE    = 2'd0,
        W_DELAY   = 2'd1,
        W_CAPTURE = 2'd2
    } wstate_t;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_BURST = 2'd1,
        R_FLUSH = 2'd2
    } rstate_t;

    localparam logic [DELAY_WIDTH-1:0]     DLY_ONE  = DELAY_WIDTH'(1);
    localparam logic [UNIT_SIZE_WIDTH-1:0] CNT_ONE  = UNIT_SIZE_WIDTH'(1);
    localparam logic [DROP_WIDTH-1:0]      DROP_MAX = '1;
    localparam logic [DROP_WIDTH-1:0]      DROP_ONE = DROP_WIDTH'(1);

    wstate_t                    w_state_q, w_state_d;
    rstate_t                    r_state_q, r_state_d;

    logic [DELAY_WIDTH-1:0]     dly_cnt_q, dly_cnt_d;
    logic [UNIT_SIZE_WIDTH-1:0] wcnt_q,    wcnt_d;
    logic [UNIT_SIZE_WIDTH-1:0] wdec_q,    wdec_d;
    logic [DROP_WIDTH-1:0]      drop_q,    drop_d;
    logic [DATA_WIDTH-1:0]      wdata_q;

    logic [UNIT_SIZE_WIDTH-1:0] rcnt_q,    rcnt_d;
    logic [UNIT_SIZE_WIDTH-1:0] rdec_q,    rdec_d;
    logic [UNIT_SIZE_WIDTH-1:0] beat_q,    beat_d;

    logic                       w_last;
    logic                       r_last;
    logic                       beat_last;

    assign w_last    = (wcnt_q == wdec_q);
    assign r_last    = (rcnt_q == rdec_q);
    assign beat_last = (beat_q == rdec_q);

    // ---------------------------------------------------------------
    // State and datapath registers
    // ---------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            dly_cnt_q <= '0;
            wcnt_q    <= '0;
            wdec_q    <= '0;
            drop_q    <= '0;
            wdata_q   <= '0;
            rcnt_q    <= '0;
            rdec_q    <= '0;
            beat_q    <= '0;
        end else begin
            dly_cnt_q <= dly_cnt_d;
            wcnt_q    <= wcnt_d;
            wdec_q    <= wdec_d;
            drop_q    <= drop_d;
            // One-clock pipe: the write in cycle N carries the sample of N-1.
            wdata_q   <= i_adc_data;
            rcnt_q    <= rcnt_d;
            rdec_q    <= rdec_d;
            beat_q    <= beat_d;
        end
    end

    // ---------------------------------------------------------------
    // Write sequencer: next state
    // ---------------------------------------------------------------
    always_comb begin
        w_state_d = w_state_q;
        unique case (w_state_q)
            W_IDLE: begin
                if (i_trig && !i_fifo_full) begin
                    if (i_delay == '0) begin
                        w_state_d = W_CAPTURE;
                    end else begin
                        w_state_d = W_DELAY;
                    end
                end
            end
            W_DELAY: begin
                if (dly_cnt_q == DLY_ONE) begin
                    w_state_d = W_CAPTURE;
                end
            end
            W_CAPTURE: begin
                if (w_last) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Write sequencer counters; unit size is frozen at trigger acceptance.
    always_comb begin
        dly_cnt_d = dly_cnt_q;
        wcnt_d    = wcnt_q;
        wdec_d    = wdec_q;
        drop_d    = drop_q;
        unique case (w_state_q)
            W_IDLE: begin
                if (i_trig) begin
                    if (i_fifo_full) begin
                        if (drop_q != DROP_MAX) begin
                            drop_d = drop_q + DROP_ONE;
                        end
                    end else begin
                        dly_cnt_d = i_delay;
                        wdec_d    = i_unit_size_dec;
                        wcnt_d    = '0;
                    end
                end
            end
            W_DELAY: begin
                dly_cnt_d = dly_cnt_q - DLY_ONE;
            end
            W_CAPTURE: begin
                if (w_last) begin
                    wcnt_d = '0;
                end else begin
                    wcnt_d = wcnt_q + CNT_ONE;
                end
            end
            default: begin
                dly_cnt_d = '0;
                wcnt_d    = '0;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Read sequencer: next state
    // ---------------------------------------------------------------
    always_comb begin
        r_state_d = r_state_q;
        unique case (r_state_q)
            R_IDLE: begin
                if (!i_fifo_empty && i_tx_ready) begin
                    r_state_d = R_BURST;
                end
            end
            R_BURST: begin
                if (i_tx_ready && r_last) begin
                    r_state_d = R_FLUSH;
                end
            end
            R_FLUSH: begin
                // Leave only once the final beat of the unit has come back.
                if (i_fifo_rd_effect && beat_last) begin
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Read counters: rcnt counts strobes issued, beat counts data returned.
    always_comb begin
        rcnt_d = rcnt_q;
        rdec_d = rdec_q;
        beat_d = beat_q;
        unique case (r_state_q)
            R_IDLE: begin
                if (!i_fifo_empty && i_tx_ready) begin
                    rdec_d = i_unit_size_dec;
                    rcnt_d = '0;
                end
            end
            R_BURST: begin
                if (i_tx_ready) begin
                    if (r_last) begin
                        rcnt_d = '0;
                    end else begin
                        rcnt_d = rcnt_q + CNT_ONE;
                    end
                end
            end
            R_FLUSH: begin
                rcnt_d = '0;
            end
            default: rcnt_d = '0;
        endcase
        if (i_fifo_rd_effect) begin
            if (beat_last) begin
                beat_d = '0;
            end else begin
                beat_d = beat_q + CNT_ONE;
            end
        end
    end

    // ---------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------
    always_comb begin
        o_fifo_wr    = (w_state_q == W_CAPTURE);
        o_fifo_wdata = wdata_q;
        o_fifo_rd    = (r_state_q == R_BURST) && i_tx_ready;
        o_tx_valid   = i_fifo_rd_effect;
        o_tx_data    = i_fifo_rdata;
        o_tx_sop     = i_fifo_rd_effect && (beat_q == '0);
        o_tx_eop     = i_fifo_rd_effect && beat_last;
        o_drop_cnt   = drop_q;
        o_busy       = (w_state_q != W_IDLE) || (r_state_q != R_IDLE);
    end

endmodule
